warp_xwb: RTL

WARP_XWB -- requirements
Module: warp_xwb

---
 rtl/warp_xwb.sv | 117 +++++++++++
 1 files changed

// File: rtl/warp_xwb.sv
// warp_xwb: two-port register-file writeback arbiter for A/B results with a queued divider (C) path.
// Ports:
//   i_clk, i_rst                        clock, asynchronous active-high reset
//   i_a_valid/i_a_rd/i_a_data           A result, always owns write port 1
//   i_b_valid/i_b_rd/i_b_data           B result, always owns write port 2
//   i_c_valid/i_c_rd/i_c_data           C result, queued in a DIV_DEPTH FIFO
//   o_rd1_wen/o_rd1_addr/o_rd1_wdata    registered write port 1
//   o_rd2_wen/o_rd2_addr/o_rd2_wdata    registered write port 2
//   o_div_full, o_div_empty             FIFO occupancy flags
//   o_collision                         A and B hit the same rd (aligned with port 1 write)
//   o_overflow                          sticky: C result dropped on a full FIFO
module warp_xwb #(
    parameter int DIV_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_rd,
    input  logic [63:0] i_a_data,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_rd,
    input  logic [63:0] i_b_data,
    input  logic        i_c_valid,
    input  logic [4:0]  i_c_rd,
    input  logic [63:0] i_c_data,
    output logic        o_rd1_wen,
    output logic [4:0]  o_rd1_addr,
    output logic [63:0] o_rd1_wdata,
    output logic        o_rd2_wen,
    output logic [4:0]  o_rd2_addr,
    output logic [63:0] o_rd2_wdata,
    output logic        o_div_full,
    output logic        o_div_empty,
    output logic        o_collision,
    output logic        o_overflow
);
    localparam int AW = $clog2(DIV_DEPTH);
    logic [4:0]    rd_mem   [DIV_DEPTH];
    logic [63:0]   data_mem [DIV_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wen1_q, wen1_d, wen2_q, wen2_d, coll_q, coll_d, ovf_q, ovf_d;
    logic [4:0]    addr1_q, addr1_d, addr2_q, addr2_d, head_rd;
    logic [63:0]   data1_q, data1_d, data2_q, data2_d, head_data;
    logic          a_w, b_v, b_w, c_w, coll, full, head_ok, pop1, pop2, pop, push;
    always_comb begin
        a_w       = i_a_valid && i_a_rd != 5'd0;
        b_v       = i_b_valid && i_b_rd != 5'd0;
        c_w       = i_c_valid && i_c_rd != 5'd0;
        coll      = a_w && b_v && i_a_rd == i_b_rd;
        b_w       = b_v && !coll;
        full      = cnt_q == (AW+1)'(DIV_DEPTH);
        head_rd   = rd_mem[rp_q];
        head_data = data_mem[rp_q];
        // head must not target a register being written by A or B in the same cycle
        head_ok   = cnt_q != '0 && !(a_w && head_rd == i_a_rd) && !(b_w && head_rd == i_b_rd);
        pop1      = head_ok && !a_w;
        pop2      = head_ok && a_w && !b_w;
        pop       = pop1 || pop2;
        push      = c_w && (!full || pop);
        wen1_d    = a_w || pop1;
        addr1_d   = a_w ? i_a_rd : pop1 ? head_rd : 5'd0;
        data1_d   = a_w ? i_a_data : pop1 ? head_data : 64'd0;
        wen2_d    = b_w || pop2;
        addr2_d   = b_w ? i_b_rd : pop2 ? head_rd : 5'd0;
        data2_d   = b_w ? i_b_data : pop2 ? head_data : 64'd0;
        coll_d    = coll;
        ovf_d     = ovf_q || (c_w && full && !pop);
        wp_d      = wp_q + AW'(push);
        rp_d      = rp_q + AW'(pop);
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wen1_q  <= 1'b0;
            addr1_q <= '0;
            data1_q <= '0;
            wen2_q  <= 1'b0;
            addr2_q <= '0;
            data2_q <= '0;
            coll_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            wen1_q  <= wen1_d;
            addr1_q <= addr1_d;
            data1_q <= data1_d;
            wen2_q  <= wen2_d;
            addr2_q <= addr2_d;
            data2_q <= data2_d;
            coll_q  <= coll_d;
            ovf_q   <= ovf_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end
    // storage needs no reset: entries are only read while the count says they are live
    always_ff @(posedge i_clk) begin
        if (push) begin
            rd_mem[wp_q]   <= i_c_rd;
            data_mem[wp_q] <= i_c_data;
        end
    end
    assign o_rd1_wen   = wen1_q;
    assign o_rd1_addr  = addr1_q;
    assign o_rd1_wdata = data1_q;
    assign o_rd2_wen   = wen2_q;
    assign o_rd2_addr  = addr2_q;
    assign o_rd2_wdata = data2_q;
    assign o_collision = coll_q;
    assign o_overflow  = ovf_q;
    assign o_div_full  = cnt_q == (AW+1)'(DIV_DEPTH);
    assign o_div_empty = cnt_q == '0;
endmodule
